// File: rtl/array_arbiter_pkg.sv
// Shared types and helpers for the array arbiter: FSM state encoding, index width, flattened-bus slicing.
// No logic; latency and backpressure are defined by the modules that import this package.
// Default ADDRN/INTN widths live here so every file agrees on them.
`ifndef ARRAY_ARBITER_PKG_SV
`define ARRAY_ARBITER_PKG_SV

`define ARB_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package array_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  localparam int ARB_ADDRN_DEFAULT = 8;
  localparam int ARB_INTN_DEFAULT  = 16;
  localparam int ARB_N_MAX         = 8;

  // Grant-index width; a single requester still needs one bit to hold index 0.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/array_arbiter_pick.sv
// Combinational N-bit picker: first set request searching upward from last+1, wrapping N-1 -> 0.
// Zero latency; no flow control, it only chooses among the requests it is shown.
// A base of N-1 makes the search start at index 0, giving plain fixed priority.
module array_arbiter_pick
  import array_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = last;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/array_arbiter.sv
// Shares one single-port array among N requesters; one outstanding op; ARRAY_ARBITER_FIXED_PRIORITY_EN selects fixed priority.
// Latency: grant 1 cycle after request, accept in ISSUE, read data 2 cycles after accept (write 2, read 3 cycles/op).
// Backpressure: grant held while arr_ready is low; a granted requester dropping req_valid aborts the op.
module array_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int ADDRN = ARB_ADDRN_DEFAULT,
  parameter int INTN  = ARB_INTN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N-1:0]       req_we,
  input  logic [N*ADDRN-1:0] req_addr,
  input  logic [N*INTN-1:0]  req_di,
  output logic [N-1:0]       req_ready,
  output logic [INTN-1:0]    req_do,
  output logic [N-1:0]       req_do_valid,
  output logic [ADDRN-1:0]   arr_addr,
  output logic               arr_we,
  output logic [INTN-1:0]    arr_di,
  output logic               arr_valid,
  input  logic               arr_ready,
  input  logic [INTN-1:0]    arr_do
);

  localparam int IW = arb_idx_w(N);

  if (N < 1 || N > ARB_N_MAX) begin : g_bad_n
    $error("array_arbiter: N must be in 1..8");
  end

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [IW-1:0] grant;
  logic [IW-1:0] pick_base;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          accept;

`ifdef ARRAY_ARBITER_FIXED_PRIORITY_EN
  assign pick_base = IW'(N - 1);
`else
  logic [IW-1:0] last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IW'(N - 1);
    end else if (accept) begin
      last <= grant;
    end
  end

  assign pick_base = last;
`endif

  array_arbiter_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (pick_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arr_valid = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = '0;
    arr_di    = '0;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // Owner withdrew its request: nothing reaches the array, re-arbitrate.
        if (!req_valid[grant]) begin
          state_nxt = ARB_IDLE;
        end else begin
          arr_valid = 1'b1;
          arr_we    = req_we[grant];
          arr_addr  = `ARB_SLICE(req_addr, grant, ADDRN);
          arr_di    = `ARB_SLICE(req_di, grant, INTN);
          if (arr_ready) begin
            accept           = 1'b1;
            req_ready[grant] = 1'b1;
            state_nxt        = req_we[grant] ? ARB_IDLE : ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Grant only moves in IDLE, so it still names the owner while the read data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      req_do       <= '0;
      req_do_valid <= '0;
    end else begin
      req_do_valid <= '0;
      if (state == ARB_IDLE && pick_found) begin
        grant <= pick_idx;
      end
      if (state == ARB_RESP) begin
        req_do              <= arr_do;
        req_do_valid[grant] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_array_arbiter.sv
// Self-checking bench for array_arbiter (N=2) with a one-cycle-latency array model and a read-data scoreboard.
module tb_array_arbiter;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [15:0] di;
  } op_t;

  typedef struct {
    int          who;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [31:0] req_di;
  logic [1:0]  req_ready;
  logic [15:0] req_do;
  logic [1:0]  req_do_valid;
  logic [7:0]  arr_addr;
  logic        arr_we;
  logic [15:0] arr_di;
  logic        arr_valid;
  logic        arr_ready;
  logic [15:0] arr_do;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] mem [256];
  logic [15:0] exp_mem [256];
  logic [15:0] rd_q;
  logic        mem_init;

  op_t    cur [2];
  op_t    q0 [$];
  op_t    q1 [$];
  bit [1:0] done;
  exp_t   sb [$];
  int     grant_log [$];
  int     acc_cyc [$];
  int     dv_cyc [$];

  array_arbiter #(.N(2), .ADDRN(8), .INTN(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_di       (req_di),
    .req_ready    (req_ready),
    .req_do       (req_do),
    .req_do_valid (req_do_valid),
    .arr_addr     (arr_addr),
    .arr_we       (arr_we),
    .arr_di       (arr_di),
    .arr_valid    (arr_valid),
    .arr_ready    (arr_ready),
    .arr_do       (arr_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'(k * 7 + 7);
    end else if (arr_valid && arr_ready) begin
      if (arr_we) mem[arr_addr] <= arr_di;
      else        rd_q <= mem[arr_addr];
    end
  end
  assign arr_do = rd_q;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    grant_log.delete();
    acc_cyc.delete();
    dv_cyc.delete();
    cyc = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        req_valid[i] = 1'b0;
        done[i]      = 1'b0;
      end
      if (!req_valid[i]) begin
        if (i == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front();
          req_valid[0] = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front();
          req_valid[1] = 1'b1;
        end
      end
      req_we[i]           = cur[i].we;
      req_addr[i*8 +: 8]  = cur[i].addr;
      req_di[i*16 +: 16]  = cur[i].di;
    end
  endtask

  // Runs queued requester ops; accepted reads push expectations, returned data pops them.
  task automatic run_ops(input int max_cyc);
    bit   fin = 1'b0;
    exp_t e;
    apply_inputs();
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          grant_log.push_back(i);
          acc_cyc.push_back(cyc);
          done[i] = 1'b1;
          if (cur[i].we) exp_mem[cur[i].addr] = cur[i].di;
          else sb.push_back('{who: i, data: exp_mem[cur[i].addr]});
        end
      end
      if (req_do_valid !== 2'b00) begin
        dv_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: do_valid=%b do=%0d, required no response", req_do_valid, req_do);
        end else begin
          e = sb.pop_front();
          if (req_do_valid !== 2'(1 << e.who) || req_do !== e.data) begin
            failures++;
            $display("FAIL sb_data: do_valid=%b do=%0d, required do_valid=%b do=%0d",
                     req_do_valid, req_do, 2'(1 << e.who), e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      apply_inputs();
      fin = (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && sb.size() == 0);
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL run_timeout: %0d responses outstanding after %0d cycles, required 0", sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1; arr_ready = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_di = '0;
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || req_do_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_handshake: ready=%b do_valid=%b, required 00 00", req_ready, req_do_valid);
    end
    checks++;
    if (arr_valid !== 1'b0 || arr_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_arr_ctl: valid=%b we=%b, required 0 0", arr_valid, arr_we);
    end
    checks++;
    if (arr_addr !== 8'd0 || arr_di !== 16'd0 || req_do !== 16'd0) begin
      failures++;
      $display("FAIL reset_data: addr=%0d di=%0d do=%0d, required 0 0 0", arr_addr, arr_di, req_do);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (arr_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: arr_valid=%b, required 0", arr_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_read();
    clear_logs();
    q0.push_back('{1'b0, 8'd5, 16'd0});
    run_ops(20);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0 || acc_cyc[0] != 2) begin
      failures++;
      $display("FAIL single_accept: grants=%0d first=%0d at cycle %0d, required 1 grant to 0 at cycle 2",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1, (acc_cyc.size() > 0) ? acc_cyc[0] : -1);
    end
    checks++;
    if (dv_cyc.size() != 1 || acc_cyc.size() != 1 || dv_cyc[0] - acc_cyc[0] != 2) begin
      failures++;
      $display("FAIL single_latency: responses=%0d, latency=%0d, required 1 response 2 cycles after accept",
               dv_cyc.size(), (dv_cyc.size() > 0 && acc_cyc.size() > 0) ? dv_cyc[0] - acc_cyc[0] : -1);
    end
    checks++;
    if (req_do !== 16'd42 || req_do_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_hold: do=%0d do_valid=%b, required 42 00", req_do, req_do_valid);
    end
  endtask

  task automatic test_contention();
    int exp_g;
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{1'b0, 8'(10 + k), 16'd0});
      q1.push_back('{1'b0, 8'(20 + k), 16'd0});
    end
    run_ops(100);
    checks++;
    if (grant_log.size() != 8) begin
      failures++;
      $display("FAIL contention_count: grants=%0d, required 8", grant_log.size());
    end
    for (int k = 0; k < grant_log.size(); k++) begin
`ifdef ARRAY_ARBITER_FIXED_PRIORITY_EN
      exp_g = (k < 4) ? 0 : 1;
`else
      exp_g = (k % 2 == 0) ? 1 : 0;
`endif
      checks++;
      if (grant_log[k] != exp_g) begin
        failures++;
        $display("FAIL contention_order[%0d]: grant=%0d, required %0d", k, grant_log[k], exp_g);
      end
      if (k > 0) begin
        checks++;
        if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
          failures++;
          $display("FAIL read_rate[%0d]: spacing=%0d, required 3", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    clear_logs();
    q1.push_back('{1'b1, 8'd3, 16'd9});
    for (int k = 0; k < 3; k++) q1.push_back('{1'b1, 8'(30 + k), 16'(100 + k)});
    run_ops(50);
    for (int k = 1; k < acc_cyc.size(); k++) begin
      checks++;
      if (acc_cyc[k] - acc_cyc[k-1] != 2 || grant_log[k] != 1) begin
        failures++;
        $display("FAIL write_rate[%0d]: spacing=%0d grant=%0d, required 2 and 1",
                 k, acc_cyc[k] - acc_cyc[k-1], grant_log[k]);
      end
    end
    q0.push_back('{1'b0, 8'd3, 16'd0});
    run_ops(20);
    checks++;
    if (req_do !== 16'd9) begin
      failures++;
      $display("FAIL write_read_data: do=%0d, required 9", req_do);
    end
    for (int k = 0; k < 3; k++) q0.push_back('{1'b0, 8'(30 + k), 16'd0});
    run_ops(50);
  endtask

  task automatic test_backpressure();
    exp_t e;
    arr_ready = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[7:0] = 8'd7;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (arr_valid !== 1'b1 || arr_addr !== 8'd7 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b addr=%0d ready=%b, required 1 7 00", k, arr_valid, arr_addr, req_ready);
      end
    end
    @(posedge clk);
    #1 arr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_accept: ready=%b, required 01", req_ready);
    end
    sb.push_back('{who: 0, data: exp_mem[7]});
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (req_do_valid !== 2'(1 << e.who) || req_do !== e.data) begin
      failures++;
      $display("FAIL bp_data: do_valid=%b do=%0d, required %b %0d", req_do_valid, req_do, 2'(1 << e.who), e.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    arr_ready = 1'b0;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[15:8] = 8'd4;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (arr_valid !== 1'b1 || arr_addr !== 8'd4) begin
      failures++;
      $display("FAIL abort_issue: valid=%b addr=%0d, required 1 4", arr_valid, arr_addr);
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (arr_valid !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL abort_drop: valid=%b ready=%b, required 0 00", arr_valid, req_ready);
    end
    @(posedge clk);
    #1 arr_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (arr_valid !== 1'b0 || req_do_valid !== 2'b00) begin
        failures++;
        $display("FAIL abort_quiet: valid=%b do_valid=%b, required 0 00", arr_valid, req_do_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_read();
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[7:0] = 8'd9;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rmr_accept: ready=%b, required 01", req_ready);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_do_valid !== 2'b00 || req_do !== 16'd0 || arr_valid !== 1'b0 || req_ready !== 2'b00 || arr_addr !== 8'd0) begin
      failures++;
      $display("FAIL rmr_outputs: do_valid=%b do=%0d arr_valid=%b ready=%b addr=%0d, required all 0",
               req_do_valid, req_do, arr_valid, req_ready, arr_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_do_valid !== 2'b00) begin
      failures++;
      $display("FAIL rmr_no_pulse: do_valid=%b, required 00", req_do_valid);
    end
    @(posedge clk);
    #1;
    clear_logs();
    q0.push_back('{1'b0, 8'd1, 16'd0});
    q1.push_back('{1'b0, 8'd2, 16'd0});
    run_ops(30);
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      failures++;
      $display("FAIL rmr_first_grant: grant=%0d, required 0", (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

`ifdef ARRAY_ARBITER_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    clear_logs();
    for (int k = 0; k < 4; k++) q0.push_back('{1'b0, 8'(40 + k), 16'd0});
    for (int k = 0; k < 2; k++) q1.push_back('{1'b0, 8'(50 + k), 16'd0});
    run_ops(80);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] != 0) begin
        failures++;
        $display("FAIL fixed_order[%0d]: grant=%0d, required 0", k, grant_log[k]);
      end
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 256; k++) exp_mem[k] = 16'(k * 7 + 7);
    cur[0] = '{1'b0, 8'd0, 16'd0};
    cur[1] = '{1'b0, 8'd0, 16'd0};
    done = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_backpressure();
    test_abort();
    test_reset_mid_read();
`ifdef ARRAY_ARBITER_FIXED_PRIORITY_EN
    test_fixed_priority();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
